// File: rtl/cheri_pkg.sv
// rtl/cheri_pkg.sv - shared owner types for the LSU / background-engine arbiter
package cheri_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_BG   = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   we;
    logic   is_cap;
  } owner_entry_t;

  // Capability accesses return two beats; everything else returns one.
  function automatic logic last_beat(input owner_entry_t e, input logic beat);
    return !e.is_cap || beat;
  endfunction

endpackage

// File: rtl/cheri_owner_fifo.sv
// rtl/cheri_owner_fifo.sv - flop FIFO recording the owner of each outstanding LSU access
module cheri_owner_fifo
  import cheri_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  owner_entry_t push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output owner_entry_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  owner_entry_t    mem_q [Depth];
  owner_entry_t    mem_d [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Pointers wrap at Depth-1 so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot for a push at full.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cheri_lsu_bg_arb.sv
// rtl/cheri_lsu_bg_arb.sv - core vs background-engine arbiter in front of the shared LSU port
module cheri_lsu_bg_arb
  import cheri_pkg::*;
#(
  parameter int unsigned StarveLimit    = 8,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic        core_is_cap_i,
  input  logic [31:0] core_addr_i,
  input  logic [32:0] core_wdata_i,
  output logic        core_req_done_o,
  output logic        core_resp_valid_o,
  output logic        core_resp_err_o,

  input  logic        bg_req_i,
  input  logic        bg_we_i,
  input  logic        bg_is_cap_i,
  input  logic [31:0] bg_addr_i,
  input  logic [32:0] bg_wdata_i,
  output logic        bg_req_done_o,
  output logic        bg_resp_valid_o,
  output logic        bg_resp_err_o,
  output logic        bg_resp_is_wr_o,
  output logic        bg_addr_incr_o,

  output logic        lsu_req_o,
  output logic        lsu_we_o,
  output logic        lsu_is_cap_o,
  output logic [31:0] lsu_addr_o,
  output logic [32:0] lsu_wdata_o,
  input  logic        lsu_req_done_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,

  output logic        spurious_resp_o
);

  logic [7:0]   starve_cnt_q, starve_cnt_d;
  logic         lock_q, lock_d;
  owner_e       sel_q, sel_d;
  logic         beat_q, beat_d;
  logic         spurious_q, spurious_d;

  owner_e       sel;
  logic         sel_req;
  logic         starve_hit;
  logic         eligible;
  logic         accept;

  logic         fifo_full, fifo_empty, fifo_pop;
  owner_entry_t fifo_head, push_entry;
  logic         beat_vld, beat_last, head_bg;

  cheri_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Response side: the registered FIFO head owns the current beat.
  always_comb begin
    beat_vld          = lsu_resp_valid_i && !fifo_empty;
    beat_last         = last_beat(fifo_head, beat_q);
    head_bg           = (fifo_head.owner == OWN_BG);
    fifo_pop          = beat_vld && beat_last;

    core_resp_valid_o = beat_vld && !head_bg;
    core_resp_err_o   = beat_vld && !head_bg && lsu_resp_err_i;
    bg_resp_valid_o   = beat_vld && head_bg;
    bg_resp_err_o     = beat_vld && head_bg && lsu_resp_err_i;
    bg_resp_is_wr_o   = beat_vld && head_bg && fifo_head.we;
    bg_addr_incr_o    = beat_vld && head_bg && fifo_head.is_cap && !beat_q;

    beat_d            = beat_q;
    if (beat_vld) begin
      beat_d = !beat_last;
    end
    spurious_d        = spurious_q || (lsu_resp_valid_i && fifo_empty);
  end

  // Request side: a stalled selection stays locked until the LSU takes it.
  always_comb begin
    starve_hit = (starve_cnt_q == 8'(StarveLimit));
    if (lock_q) begin
      sel = sel_q;
    end else if (bg_req_i && (starve_hit || !core_req_i)) begin
      sel = OWN_BG;
    end else begin
      sel = OWN_CORE;
    end
    sel_req   = (sel == OWN_BG) ? bg_req_i : core_req_i;
    eligible  = !fifo_full || fifo_pop;
    lsu_req_o = eligible && sel_req;
    accept    = lsu_req_o && lsu_req_done_i;

    lsu_we_o     = 1'b0;
    lsu_is_cap_o = 1'b0;
    lsu_addr_o   = '0;
    lsu_wdata_o  = '0;
    if (lsu_req_o) begin
      if (sel == OWN_BG) begin
        lsu_we_o     = bg_we_i;
        lsu_is_cap_o = bg_is_cap_i;
        lsu_addr_o   = bg_addr_i;
        lsu_wdata_o  = bg_wdata_i;
      end else begin
        lsu_we_o     = core_we_i;
        lsu_is_cap_o = core_is_cap_i;
        lsu_addr_o   = core_addr_i;
        lsu_wdata_o  = core_wdata_i;
      end
    end

    core_req_done_o   = accept && (sel == OWN_CORE);
    bg_req_done_o     = accept && (sel == OWN_BG);
    push_entry.owner  = sel;
    push_entry.we     = lsu_we_o;
    push_entry.is_cap = lsu_is_cap_o;

    lock_d = lsu_req_o && !lsu_req_done_i;
    sel_d  = sel;

    starve_cnt_d = starve_cnt_q;
    if (!bg_req_i || bg_req_done_o) begin
      starve_cnt_d = '0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  assign spurious_resp_o = spurious_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
      lock_q       <= 1'b0;
      sel_q        <= OWN_CORE;
      beat_q       <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lock_q       <= lock_d;
      sel_q        <= sel_d;
      beat_q       <= beat_d;
      spurious_q   <= spurious_d;
    end
  end

endmodule

// File: tb/tb_cheri_lsu_bg_arb.sv
// tb/tb_cheri_lsu_bg_arb.sv - randomized bench for cheri_lsu_bg_arb against a queue-based model
module tb_cheri_lsu_bg_arb;

  localparam int LIMIT = 8;
  localparam int MAXO  = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i, core_is_cap_i;
  logic [31:0] core_addr_i;
  logic [32:0] core_wdata_i;
  logic        core_req_done_o, core_resp_valid_o, core_resp_err_o;
  logic        bg_req_i, bg_we_i, bg_is_cap_i;
  logic [31:0] bg_addr_i;
  logic [32:0] bg_wdata_i;
  logic        bg_req_done_o, bg_resp_valid_o, bg_resp_err_o, bg_resp_is_wr_o, bg_addr_incr_o;
  logic        lsu_req_o, lsu_we_o, lsu_is_cap_o;
  logic [31:0] lsu_addr_o;
  logic [32:0] lsu_wdata_o;
  logic        lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i;
  logic        spurious_resp_o;

  always #5 clk_i = ~clk_i;

  cheri_lsu_bg_arb #(
    .StarveLimit    (LIMIT),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .core_req_i        (core_req_i),
    .core_we_i         (core_we_i),
    .core_is_cap_i     (core_is_cap_i),
    .core_addr_i       (core_addr_i),
    .core_wdata_i      (core_wdata_i),
    .core_req_done_o   (core_req_done_o),
    .core_resp_valid_o (core_resp_valid_o),
    .core_resp_err_o   (core_resp_err_o),
    .bg_req_i          (bg_req_i),
    .bg_we_i           (bg_we_i),
    .bg_is_cap_i       (bg_is_cap_i),
    .bg_addr_i         (bg_addr_i),
    .bg_wdata_i        (bg_wdata_i),
    .bg_req_done_o     (bg_req_done_o),
    .bg_resp_valid_o   (bg_resp_valid_o),
    .bg_resp_err_o     (bg_resp_err_o),
    .bg_resp_is_wr_o   (bg_resp_is_wr_o),
    .bg_addr_incr_o    (bg_addr_incr_o),
    .lsu_req_o         (lsu_req_o),
    .lsu_we_o          (lsu_we_o),
    .lsu_is_cap_o      (lsu_is_cap_o),
    .lsu_addr_o        (lsu_addr_o),
    .lsu_wdata_o       (lsu_wdata_o),
    .lsu_req_done_i    (lsu_req_done_i),
    .lsu_resp_valid_i  (lsu_resp_valid_i),
    .lsu_resp_err_i    (lsu_resp_err_i),
    .spurious_resp_o   (spurious_resp_o)
  );

  typedef struct {
    bit bg;
    bit we;
    bit cap;
  } txn_t;

  txn_t        mq[$];
  int          beat_idx;
  int          starve;
  bit          locked, locked_bg, spur;

  bit          c_req, c_we, c_cap, b_req, b_we, b_cap;
  logic [31:0] c_addr, b_addr;
  logic [32:0] c_wd, b_wd;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    beat_idx  = 0;
    starve    = 0;
    locked    = 0;
    locked_bg = 0;
    spur      = 0;
    c_req     = 0;
    b_req     = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni           = 1'b0;
    core_req_i       = 1'b0;
    bg_req_i         = 1'b0;
    lsu_req_done_i   = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i   = 1'b0;
    model_reset();
    #1;
    check_eq("rst_lsu", {lsu_req_o, lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o}, '0);
    check_eq("rst_done", {core_req_done_o, bg_req_done_o}, '0);
    check_eq("rst_resp", {core_resp_valid_o, core_resp_err_o, bg_resp_valid_o, bg_resp_err_o,
                          bg_resp_is_wr_o, bg_addr_incr_o}, '0);
    check_eq("rst_spur", spurious_resp_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic do_cycle(input bit allow_new, input int p_done, input int p_resp, input bit force_resp);
    bit   have, beat, fin, pick_bg, want, go, acc, rv;
    txn_t h;
    logic [67:0] exp_lsu;
    @(negedge clk_i);
    if (!c_req && allow_new && $urandom_range(0, 99) < 75) begin
      c_req  = 1;
      c_we   = 1'($urandom_range(0, 1));
      c_cap  = 1'($urandom_range(0, 1));
      c_addr = $urandom;
      c_wd   = {1'($urandom_range(0, 1)), 32'($urandom)};
    end
    if (!b_req && allow_new && $urandom_range(0, 99) < 40) begin
      b_req  = 1;
      b_we   = 1'($urandom_range(0, 1));
      b_cap  = 1'($urandom_range(0, 1));
      b_addr = $urandom;
      b_wd   = {1'($urandom_range(0, 1)), 32'($urandom)};
    end
    core_req_i       = c_req;
    core_we_i        = c_we;
    core_is_cap_i    = c_cap;
    core_addr_i      = c_addr;
    core_wdata_i     = c_wd;
    bg_req_i         = b_req;
    bg_we_i          = b_we;
    bg_is_cap_i      = b_cap;
    bg_addr_i        = b_addr;
    bg_wdata_i       = b_wd;
    lsu_req_done_i   = ($urandom_range(0, 99) < p_done);
    rv               = force_resp || (mq.size() > 0 && $urandom_range(0, 99) < p_resp);
    lsu_resp_valid_i = rv;
    lsu_resp_err_i   = 1'($urandom_range(0, 1));
    #1;

    have = (mq.size() > 0);
    h    = '{bg: 0, we: 0, cap: 0};
    if (have) h = mq[0];
    beat = rv && have;
    fin  = beat && (!h.cap || beat_idx == 1);

    if (locked) pick_bg = locked_bg;
    else        pick_bg = b_req && (starve == LIMIT || !c_req);
    want = pick_bg ? b_req : c_req;
    go   = want && (mq.size() < MAXO || fin);
    acc  = go && lsu_req_done_i;

    exp_lsu = '0;
    if (go) exp_lsu = pick_bg ? {1'b1, b_we, b_cap, b_addr, b_wd} : {1'b1, c_we, c_cap, c_addr, c_wd};

    check_eq("lsu_bus", {lsu_req_o, lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o}, exp_lsu);
    check_eq("req_done", {core_req_done_o, bg_req_done_o}, {acc && !pick_bg, acc && pick_bg});
    check_eq("resp", {core_resp_valid_o, core_resp_err_o, bg_resp_valid_o, bg_resp_err_o,
                      bg_resp_is_wr_o, bg_addr_incr_o},
             {beat && !h.bg, beat && !h.bg && lsu_resp_err_i, beat && h.bg,
              beat && h.bg && lsu_resp_err_i, beat && h.bg && h.we,
              beat && h.bg && h.cap && beat_idx == 0});
    check_eq("spurious", spurious_resp_o, spur);

    if (fin) begin
      void'(mq.pop_front());
      beat_idx = 0;
    end else if (beat) begin
      beat_idx = 1;
    end
    if (acc) mq.push_back(pick_bg ? '{bg: 1, we: b_we, cap: b_cap} : '{bg: 0, we: c_we, cap: c_cap});
    if (!b_req || (acc && pick_bg)) starve = 0;
    else if (starve < LIMIT)        starve = starve + 1;
    locked    = go && !lsu_req_done_i;
    locked_bg = pick_bg;
    spur      = spur || (rv && !have);
    if (acc && pick_bg)  b_req = 0;
    if (acc && !pick_bg) c_req = 0;
  endtask

  initial begin
    rst_ni = 1'b0;
    {core_req_i, core_we_i, core_is_cap_i, bg_req_i, bg_we_i, bg_is_cap_i} = '0;
    core_addr_i  = '0;
    core_wdata_i = '0;
    bg_addr_i    = '0;
    bg_wdata_i   = '0;
    {lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i} = '0;
    {c_we, c_cap, b_we, b_cap} = '0;
    c_addr = '0; c_wd = '0; b_addr = '0; b_wd = '0;
    apply_reset();

    repeat (1500) do_cycle(1, 50, 50, 0);
    repeat (800)  do_cycle(1, 90, 20, 0);
    repeat (800)  do_cycle(1, 30, 70, 0);

    for (int i = 0; i < 60 && (c_req || b_req || mq.size() > 0); i++) do_cycle(0, 100, 100, 0);
    check_eq("drain_done", {c_req, b_req, mq.size() == 0}, 3'b001);

    repeat (3) do_cycle(0, 100, 0, 1);
    check_eq("spur_sticky", spurious_resp_o, 1);

    apply_reset();
    repeat (30) do_cycle(1, 60, 0, 0);
    apply_reset();
    repeat (3) do_cycle(0, 100, 0, 1);
    repeat (200) do_cycle(1, 60, 60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
